pipe_skid_reg: RTL
==================

# pipe_skid_reg

Parametrised elastic pipeline-stage register, the successor to the fixed decode→execute stage register. It carries an arbitrary-width payload between two pipeline stages using a valid/ready handshake, with a two-entry skid buffer so `in_ready` has no combinational path from `out_ready`. Flush is supported, with optional payload zeroing, along with saturating stall and flush event counters for performance monitoring. Any stage boundary can instantiate it (F/D, D/E, E/M, M/W) by packing its fields into `in_data`.

## Interface
- `WIDTH`, 32: payload width in bits (≥1).
- `ZERO_ON_FLUSH`, 1: 1 = stored payload registers are cleared to 0 on flush; 0 = payload is left unchanged and only valid bits are cleared.
- `CNT_WIDTH`, 16: width of each performance counter (≥2).

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `flush`  in  1  kill all stored entries this cycle; highest priority.
- `in_valid`  in  1  upstream payload valid.
- `in_ready`  out  1  stage can accept this cycle.
- `in_data`  in  WIDTH  upstream payload.
- `out_valid`  out  1  payload present at output.
- `out_ready`  in  1  downstream accepts this cycle.
- `out_data`  out  WIDTH  output payload (main register M).
- `occupancy`  out  2  number of held entries (0, 1 or 2).
- `cnt_clr`  in  1  synchronous clear of both counters.
- `stall_cnt`  out  CNT_WIDTH  cycles with `out_valid && !out_ready`, saturating.
- `flush_cnt`  out  CNT_WIDTH  cycles with `flush` high while `occupancy != 0`, saturating.

## Operation
- Storage: main register M (drives `out_data`) and skid register S. State is EMPTY (0 entries), BUSY (M valid) or FULL (M and S valid). `occupancy` is 0/1/2 respectively.
- `in_ready = !rst && !flush && state != FULL`. The value depends only on state and `flush`, never on `out_ready`.
- `out_valid = (state != EMPTY)`.
- Accept = `in_valid && in_ready`. Fire = `out_valid && out_ready`.
- Transitions when `flush` = 0:
  - EMPTY: accept → M←in, BUSY.
  - BUSY: accept & fire → M←in, stay BUSY. Accept & !fire → S←in, FULL. !accept & fire → EMPTY. Otherwise hold.
  - FULL: fire → M←S, BUSY. Otherwise hold. No accept is possible in FULL.
- Flush (any state): next state is EMPTY and the input is not accepted. If `ZERO_ON_FLUSH`=1, M and S are set to 0. A flush coinciding with fire still leaves EMPTY; downstream has consumed M in that cycle.
- Payload registers hold their value whenever they are not loaded. Data is never reordered or duplicated.
- Counters:
  - `cnt_clr` has priority over increment: the counter goes to 0 that cycle.
  - Increments saturate at 2^CNT_WIDTH−1 and never wrap.

## Timing
- Reset (async assert, sync-to-clk deassert handled externally): state EMPTY, M=S=0, `out_valid`=0, `occupancy`=0, counters 0, `in_ready`=0 while `rst` is high.
- First cycle after reset release: `in_ready`=1, provided `flush`=0.
- Latency: a payload accepted at edge N appears on `out_data` with `out_valid`=1 after edge N.
- Throughput: 1 transfer/cycle sustained while `out_ready`=1.
- Backpressure: when `out_ready` drops, the stage absorbs exactly one more beat into S. `in_ready` falls on the following edge.
- Recovery from FULL: after the first fire, `in_ready` returns to 1 on the next cycle. S drains to M at that same edge.
- Reset asserted mid-operation: all state is lost immediately (asynchronous). No output glitches other than the reset values.

## Test plan
- Reset/idle: hold `rst`=1 with `in_valid`=1 → `in_ready`=0, `out_valid`=0, `out_data`=0, `occupancy`=0. Release → `in_ready`=1.
- Streaming: `out_ready`=1, send 0x11, 0x22, 0x33 on consecutive cycles → same values on `out_data` one cycle later, back-to-back. `stall_cnt`=0.
- Skid/backpressure: stream 0xA1, 0xA2, 0xA3 with `out_ready`=0 from the 2nd cycle → `occupancy`=2, `in_ready`=0, 0xA3 held upstream. Hold 3 cycles, then `out_ready`=1 → output order 0xA1, 0xA2, 0xA3. `stall_cnt` counts every held cycle.
- Flush in FULL with `ZERO_ON_FLUSH`=1 and `in_valid`=1 → next cycle EMPTY, `out_valid`=0, `out_data`=0, input not taken, `flush_cnt`=1. Flush while EMPTY → `flush_cnt` unchanged.
- Saturation with `CNT_WIDTH`=2: 6 stall cycles → `stall_cnt`=3. `cnt_clr` pulse together with a stall → 0.
- Async reset mid-FULL: assert `rst` between edges → outputs go to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pipe_skid_reg.sv
// Elastic valid/ready pipeline-stage register with a two-entry skid buffer,
// flush with optional payload zeroing, and saturating stall/flush counters.
module pipe_skid_reg #(
    parameter int WIDTH         = 32,
    parameter bit ZERO_ON_FLUSH = 1'b1,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [1:0]           occupancy,
    input  logic                 cnt_clr,
    output logic [CNT_WIDTH-1:0] stall_cnt,
    output logic [CNT_WIDTH-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    state_t           state;
    logic [WIDTH-1:0] m_data;
    logic [WIDTH-1:0] s_data;
    logic             accept;
    logic             fire;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
        return (&c) ? c : c + CNT_ONE;
    endfunction

    // in_ready is a function of registered state and flush only, so the
    // downstream out_ready never reaches it combinationally.
    assign in_ready  = !rst && !flush && (state != FULL);
    assign out_valid = (state != EMPTY);
    assign out_data  = m_data;
    assign accept    = in_valid && in_ready;
    assign fire      = out_valid && out_ready;

    always_comb begin
        occupancy = 2'd0;
        case (state)
            BUSY:    occupancy = 2'd1;
            FULL:    occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= EMPTY;
            m_data <= '0;
            s_data <= '0;
        end else if (flush) begin
            state <= EMPTY;
            if (ZERO_ON_FLUSH) begin
                m_data <= '0;
                s_data <= '0;
            end
        end else begin
            unique case (state)
                EMPTY: begin
                    if (accept) begin
                        m_data <= in_data;
                        state  <= BUSY;
                    end
                end
                BUSY: begin
                    if (accept && fire) begin
                        m_data <= in_data;
                    end else if (accept) begin
                        s_data <= in_data;
                        state  <= FULL;
                    end else if (fire) begin
                        state <= EMPTY;
                    end
                end
                FULL: begin
                    // Skid entry is the older of the two once M has left.
                    if (fire) begin
                        m_data <= s_data;
                        state  <= BUSY;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (cnt_clr) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (out_valid && !out_ready) stall_cnt <= sat_inc(stall_cnt);
            if (flush && (state != EMPTY)) flush_cnt <= sat_inc(flush_cnt);
        end
    end

endmodule
